// File: rtl/alu_ops_pkg.sv
// Package shared by the serial-shift ALU execution unit.
// Holds the ALU operation encoding, the execution FSM state encoding and
// small decode helpers used by the top and by the serial shifter.
package alu_ops_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_XOR = 4'b0101,
    OP_SUB = 4'b0110,
    OP_SLL = 4'b0111,
    OP_EQ  = 4'b1000,
    OP_NE  = 4'b1001,
    OP_GE  = 4'b1010,
    OP_LT  = 4'b1100,
    OP_SRA = 4'b1101,
    OP_SRL = 4'b1111
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Operations handled by the serial shifter rather than the 1-cycle datapath.
  function automatic logic is_shift(alu_op_t op);
    case (op)
      OP_SLL, OP_SRA, OP_SRL: is_shift = 1'b1;
      default:                is_shift = 1'b0;
    endcase
  endfunction

  // Operations whose result is a single condition bit.
  function automatic logic is_compare(alu_op_t op);
    case (op)
      OP_EQ, OP_NE, OP_GE, OP_LT: is_compare = 1'b1;
      default:                    is_compare = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_serial_exec_if.sv
// Handshake bundle between decode, the execution unit and writeback.
// Request side : in_valid/in_ready, operation, src_a, src_b.
// Response side: out_valid/out_ready, alu_result, branch_taken, illegal_op.
// master = producer/consumer around the unit, slave = the execution unit.
interface alu_serial_exec_if #(parameter int DATA_WIDTH = 32);

  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            operation;
  logic [DATA_WIDTH-1:0] src_a;
  logic [DATA_WIDTH-1:0] src_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  branch_taken;
  logic                  illegal_op;

  modport master (
    output in_valid, operation, src_a, src_b, out_ready,
    input  in_ready, out_valid, alu_result, branch_taken, illegal_op
  );

  modport slave (
    input  in_valid, operation, src_a, src_b, out_ready,
    output in_ready, out_valid, alu_result, branch_taken, illegal_op
  );

endinterface

// File: rtl/alu_shift_unit.sv
// Serial shifter: one bit position per step.
// Ports: clk, reset (sync active-low), load (capture data/amount/op),
// step (shift once, count down), load_op (selects SLL/SRL/SRA),
// load_data, load_amount, shifted (acc after one more step), last (cnt==1).
module alu_shift_unit
  import alu_ops_pkg::*;
#(
  parameter  int DATA_WIDTH  = 32,
  localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   step,
  input  alu_op_t                load_op,
  input  logic [DATA_WIDTH-1:0]  load_data,
  input  logic [SHAMT_WIDTH-1:0] load_amount,
  output logic [DATA_WIDTH-1:0]  shifted,
  output logic                   last
);

  logic [DATA_WIDTH-1:0]  acc_r;
  logic [SHAMT_WIDTH-1:0] cnt_r;
  logic                   left_r;
  logic                   arith_r;

  // Accumulator, down-counter and direction flags; direction is latched at
  // load so later changes on the operation input cannot affect the shift.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_r   <= {DATA_WIDTH{1'b0}};
      cnt_r   <= {SHAMT_WIDTH{1'b0}};
      left_r  <= 1'b0;
      arith_r <= 1'b0;
    end else if (load) begin
      acc_r   <= load_data;
      cnt_r   <= load_amount;
      left_r  <= (load_op == OP_SLL);
      arith_r <= (load_op == OP_SRA);
    end else if (step) begin
      acc_r   <= shifted;
      cnt_r   <= cnt_r - SHAMT_WIDTH'(1);
    end
  end

  // One-bit shift of the accumulator; the SRA fill bit stays equal to the
  // original sign because each arithmetic step replicates the current MSB.
  always_comb begin
    shifted = {DATA_WIDTH{1'b0}};
    if (left_r) begin
      shifted = {acc_r[DATA_WIDTH-2:0], 1'b0};
    end else begin
      shifted = {arith_r & acc_r[DATA_WIDTH-1], acc_r[DATA_WIDTH-1:1]};
    end
  end

  assign last = (cnt_r == SHAMT_WIDTH'(1));

endmodule

// File: rtl/alu_serial_exec.sv
// ALU execution unit: single-cycle logic/add/sub/compare, serial shifts.
// Ports: clk, reset (sync active-low), bus (alu_serial_exec_if.slave) carrying
// the operand handshake in and the result handshake out.
module alu_serial_exec
  import alu_ops_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input logic               clk,
  input logic               reset,
  alu_serial_exec_if.slave  bus
);

  localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);

  state_t                  state_r;
  state_t                  state_n;
  alu_op_t                 op_s;
  logic                    accept_s;
  logic                    load_s;
  logic                    step_s;
  logic                    shift_last_s;
  logic [SHAMT_WIDTH-1:0]  shamt_s;
  logic [DATA_WIDTH-1:0]   shifted_s;
  logic [DATA_WIDTH-1:0]   arith_s;
  logic [DATA_WIDTH-1:0]   op_result_s;
  logic                    cond_s;
  logic                    illegal_s;
  logic [DATA_WIDTH-1:0]   result_r;
  logic                    branch_r;
  logic                    illegal_r;

  assign op_s    = alu_op_t'(bus.operation);
  assign shamt_s = bus.src_b[SHAMT_WIDTH-1:0];

  alu_shift_unit #(.DATA_WIDTH(DATA_WIDTH)) u_shift (
    .clk         (clk),
    .reset       (reset),
    .load        (load_s),
    .step        (step_s),
    .load_op     (op_s),
    .load_data   (bus.src_a),
    .load_amount (shamt_s),
    .shifted     (shifted_s),
    .last        (shift_last_s)
  );

  // Single-cycle datapath; shift ops pass src_a so a zero shift is done here.
  always_comb begin
    arith_s   = {DATA_WIDTH{1'b0}};
    cond_s    = 1'b0;
    illegal_s = 1'b0;
    case (op_s)
      OP_AND:                 arith_s = bus.src_a & bus.src_b;
      OP_OR:                  arith_s = bus.src_a | bus.src_b;
      OP_XOR:                 arith_s = bus.src_a ^ bus.src_b;
      OP_ADD:                 arith_s = bus.src_a + bus.src_b;
      OP_SUB:                 arith_s = bus.src_a - bus.src_b;
      OP_EQ:                  cond_s  = (bus.src_a == bus.src_b);
      OP_NE:                  cond_s  = (bus.src_a != bus.src_b);
      OP_GE:                  cond_s  = ($signed(bus.src_a) >= $signed(bus.src_b));
      OP_LT:                  cond_s  = ($signed(bus.src_a) <  $signed(bus.src_b));
      OP_SLL, OP_SRL, OP_SRA: arith_s = bus.src_a;
      default:                illegal_s = 1'b1;
    endcase
  end

  assign op_result_s = is_compare(op_s) ? {{(DATA_WIDTH-1){1'b0}}, cond_s} : arith_s;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // FSM next-state and shifter control.
  always_comb begin
    state_n  = state_r;
    accept_s = 1'b0;
    load_s   = 1'b0;
    step_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          accept_s = 1'b1;
          if (is_shift(op_s)) begin
            load_s = 1'b1;
            if (shamt_s == {SHAMT_WIDTH{1'b0}}) begin
              state_n = ST_DONE;
            end else begin
              state_n = ST_SHIFT;
            end
          end else begin
            state_n = ST_DONE;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        step_s = 1'b1;
        if (shift_last_s) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_DONE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Result registers: captured at accept, overwritten by the final shift
  // step, otherwise held so the DONE outputs stay stable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      result_r  <= {DATA_WIDTH{1'b0}};
      branch_r  <= 1'b0;
      illegal_r <= 1'b0;
    end else if (accept_s) begin
      result_r  <= op_result_s;
      branch_r  <= cond_s;
      illegal_r <= illegal_s;
    end else if (step_s && shift_last_s) begin
      result_r  <= shifted_s;
    end
  end

  assign bus.in_ready     = (state_r == ST_IDLE);
  assign bus.out_valid    = (state_r == ST_DONE);
  assign bus.alu_result   = result_r;
  assign bus.branch_taken = branch_r;
  assign bus.illegal_op   = illegal_r;

endmodule

// File: doc/alu_serial_exec.md
Name: alu_serial_exec

Overview:
Execution unit that consumes the 4-bit ALU operation code produced by the ALU control decode and performs the selected operation on two operands. Single-cycle ops (logic, add/sub, compares) complete in 1 cycle. Shifts use an area-saving serial shifter, 1 bit per cycle. Operands enter and results leave through valid/ready handshakes, so the block fits a multi-cycle datapath between decode and writeback/branch resolution.

Parameters:
DATA_WIDTH, 32, operand/result width
SHAMT_WIDTH, $clog2(DATA_WIDTH), shift-amount bits taken from src_b (derived, not overridden)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
in_valid  in  1  operation/operands valid
in_ready  out  1  block accepts new operation (high only in IDLE)
operation  in  4  ALU operation code (alu_op_t)
src_a  in  DATA_WIDTH  operand A
src_b  in  DATA_WIDTH  operand B / shift amount
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
alu_result  out  DATA_WIDTH  result
branch_taken  out  1  compare condition true (compare ops only)
illegal_op  out  1  operation code unassigned

Behaviour:
- Codes: AND 0000, OR 0001, ADD 0010, XOR 0101, SUB 0110, SLL 0111, EQ 1000, NE 1001, GE 1010, LT 1100, SRA 1101, SRL 1111. All other codes are illegal.
- Reset (reset==0 at edge): state IDLE, out_valid=0, alu_result=0, branch_taken=0, illegal_op=0, shift counter=0. A reset during SHIFT or DONE aborts the operation. No result is ever presented for it.
- FSM states IDLE, SHIFT, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE, in_valid=1 (accept at edge T):
  - Non-shift op: result registered; DONE from T+1.
  - Shift op: acc<=src_a, cnt<=src_b[SHAMT_WIDTH-1:0]. Upper src_b bits are ignored.
    - cnt==0: DONE at T+1 with alu_result=src_a.
    - Otherwise SHIFT.
- SHIFT: each cycle acc shifts by 1 and cnt decrements.
  - SLL: zero fill.
  - SRL: zero fill.
  - SRA: fill with src_a MSB.
  - On the cycle cnt==1, the final shift is applied and the FSM goes to DONE.
  - Total latency: out_valid first high in cycle T+1+shamt.
- DONE: alu_result, branch_taken and illegal_op are held stable while out_valid=1. When out_ready=1, the FSM goes to IDLE next cycle. No new operation is accepted in DONE, so minimum issue interval is 2 cycles.
- Arithmetic: ADD/SUB wrap modulo 2^DATA_WIDTH. GE and LT are signed two's-complement compares.
- Compare ops (EQ/NE/GE/LT): alu_result={0..0,cond}, branch_taken=cond. LT doubles as set-less-than.
- Non-compare ops: branch_taken=0.
- Illegal code: 1-cycle latency, alu_result=0, branch_taken=0, illegal_op=1. illegal_op is 0 for all legal codes.
- in_valid while not in IDLE is ignored. Inputs are sampled only at the accept edge; changes afterward have no effect.

Decomposition:
- Package alu_ops_pkg holds:
  - typedef enum logic [3:0] alu_op_t with the codes above
  - typedef enum for FSM state
  - function is_shift(alu_op_t)
  - function is_compare(alu_op_t)
- Sub-module alu_shift_unit holds the serial shifter: acc register, cnt down-counter, load/step/done interface, direction/arith select. The top holds the FSM, single-cycle datapath and handshake.

Test Plan:
1. ADD 0x7FFFFFFF+0x00000001, out_ready held 0 for 3 cycles -> out_valid high from T+1, alu_result=0x80000000 stable throughout, IDLE one cycle after out_ready=1.
2. SUB 5-7 -> 0xFFFFFFFE. LT(0xFFFFFFFE,1) -> result 1, branch_taken 1. GE(0xFFFFFFFF,0xFFFFFFFF) -> branch_taken 1. NE(3,3) -> branch_taken 0. EQ(3,3) -> 1.
3. SLL src_a=0x1, src_b=0x25 (shamt 5) -> in_ready low T+1..T+6, result 0x00000020 at T+6. Shamt 0 (src_b=0x20) -> src_a at T+1.
4. SRA 0x80000000 by 31 -> 0xFFFFFFFF at T+32. SRL same -> 0x00000001. SRA 0x40000000 by 1 -> 0x20000000.
5. Reset driven low at T+3 of a shamt-10 SLL -> out_valid stays 0, in_ready=1 after reset release. Next ADD 1+1 returns 2, not a stale shift value.
6. operation=0011 -> illegal_op=1, alu_result=0, branch_taken=0 at T+1. Following AND 0xF0F0&0xFF00 -> 0xF000 with illegal_op=0.
